// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg : shared definitions for the data-memory access controller
//          (bit_type access codes, FSM state encoding, store-lane merge).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dm_pkg;

  // Access size / extension codes carried on bit_type
  localparam logic [2:0] BT_WORD  = 3'b000;
  localparam logic [2:0] BT_HALF  = 3'b001;
  localparam logic [2:0] BT_BYTE  = 3'b010;
  localparam logic [2:0] BT_HALFU = 3'b011;
  localparam logic [2:0] BT_BYTEU = 3'b100;

  // Controller state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } dm_state_e;

  function automatic logic bt_is_valid(input logic [2:0] bt);
    return (bt <= BT_BYTEU);
  endfunction

  function automatic logic bt_is_half(input logic [2:0] bt);
    return (bt == BT_HALF) || (bt == BT_HALFU);
  endfunction

  function automatic logic bt_is_byte(input logic [2:0] bt);
    return (bt == BT_BYTE) || (bt == BT_BYTEU);
  endfunction

  // Insert the low half/byte of wdat into the lane of old_word chosen by lane;
  // every other byte of old_word passes through untouched.
  function automatic logic [31:0] dm_merge(input logic [31:0] old_word,
                                           input logic [15:0] wdat,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  bt);
    logic [31:0] merged;
    merged = old_word;
    if (bt_is_half(bt)) begin
      if (lane[1]) merged[31:16] = wdat;
      else         merged[15:0]  = wdat;
    end else if (bt_is_byte(bt)) begin
      case (lane)
        2'd0:    merged[7:0]   = wdat[7:0];
        2'd1:    merged[15:8]  = wdat[7:0];
        2'd2:    merged[23:16] = wdat[7:0];
        default: merged[31:24] = wdat[7:0];
      endcase
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_load_ext.sv
// ---------------------------------------------------------------------------
// dm_load_ext : combinational lane select and sign/zero extension of a
//               memory word for loads.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  bit_type_i,
  output logic [31:0] data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Pick the addressed half/byte, then extend according to the access type
  always_comb begin
    half_sel = lane_i[1] ? data_i[31:16] : data_i[15:0];
    case (lane_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    case (bit_type_i)
      BT_WORD:  data_o = data_i;
      BT_HALF:  data_o = {{16{half_sel[15]}}, half_sel};
      BT_HALFU: data_o = {16'd0, half_sel};
      BT_BYTE:  data_o = {{24{byte_sel[7]}}, byte_sel};
      BT_BYTEU: data_o = {24'd0, byte_sel};
      default:  data_o = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// dm_access_ctrl : data-memory access controller between the pipeline MEM
//                  stage and a single-port synchronous RAM. Handles word
//                  stores directly, loads via read/capture, and half/byte
//                  stores via read-modify-write.
// Optional feature: define DM_ALIGN_EXC_EN to flag misaligned word/half
//                  accesses (exc_adel / exc_ades) instead of performing them.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [2:0]        bit_type,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  dm_state_e         state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       rdata_q;
  logic              we_q;
  logic [2:0]        type_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [31:0]       ext_data;
  logic              accept;
  logic              misalign;
  logic              addr_unused;

  // A new request may be taken while idle or in the completion cycle
  assign accept      = req && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  // Byte address bits above the RAM word range are intentionally ignored
  assign addr_unused = ^addr[31:ADDR_W+2];

`ifdef DM_ALIGN_EXC_EN
  logic exc_adel_q, exc_ades_q;

  assign misalign = ((bit_type == BT_WORD) && (addr[1:0] != 2'b00)) ||
                    (bt_is_half(bit_type) && addr[0]);

  // Exception flags are raised for exactly the RESP cycle of a rejected access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_adel_q <= 1'b0;
      exc_ades_q <= 1'b0;
    end else begin
      exc_adel_q <= accept && misalign && !we;
      exc_ades_q <= accept && misalign && we;
    end
  end

  assign exc_adel = exc_adel_q;
  assign exc_ades = exc_ades_q;
`else
  // Misaligned word/half accesses are performed on the containing word
  assign misalign = 1'b0;
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: word stores skip the read, sub-word stores do read-modify-write
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (!bt_is_valid(bit_type) || misalign) state_d = ST_RESP;
          else if (we && (bit_type == BT_WORD))   state_d = ST_WR;
          else                                    state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; RAM strobes are precomputed from the next state
  always_comb begin
    busy     = (state_q == ST_RD) || (state_q == ST_CAP) || (state_q == ST_WR);
    done     = (state_q == ST_RESP);
    mem_en_d = (state_d == ST_RD) || (state_d == ST_WR);
    mem_we_d = (state_d == ST_WR);
  end

  // RAM strobe registers, cleared at once by reset so no write escapes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
    end
  end

  dm_load_ext u_load_ext (
    .data_i     (mem_rdata),
    .lane_i     (lane_q),
    .bit_type_i (type_q),
    .data_o     (ext_data)
  );

  // Request latch on accept; in CAP either merge store data or capture load data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      type_q      <= BT_WORD;
      lane_q      <= 2'b00;
      wdata_q     <= 16'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else if (accept) begin
      we_q        <= we;
      type_q      <= bit_type;
      lane_q      <= addr[1:0];
      wdata_q     <= wdata[15:0];
      mem_addr_q  <= addr[ADDR_W+1:2];
      mem_wdata_q <= wdata;
      if (!bt_is_valid(bit_type)) rdata_q <= 32'd0;
    end else if (state_q == ST_CAP) begin
      if (we_q) mem_wdata_q <= dm_merge(mem_rdata, wdata_q, lane_q, type_q);
      else      rdata_q     <= ext_data;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_access_ctrl : bench for dm_access_ctrl with a behavioural RAM, a
//                     transaction-level reference model and per-cycle compare.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [2:0]  bit_type;
  logic        busy, done, exc_adel, exc_ades, mem_en, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .bit_type(bit_type), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // ---------------- behavioural synchronous RAM ----------------
  logic [31:0] ram [0:4095];
  int rd_cnt, wr_cnt;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
    rd_cnt = 0; wr_cnt = 0; mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) begin
          ram[mem_addr] <= mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          mem_rdata <= ram[mem_addr];
          rd_cnt <= rd_cnt + 1;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mm [0:4095];
  int          m_left, m_accepts;
  logic        m_done, m_adel, m_ades;
  logic [31:0] m_rdata;
  logic        p_we;
  logic [31:0] p_addr, p_wd;
  logic [2:0]  p_bt;
  int          p_idx, p_rd0, p_wr0, p_exp_rd, p_exp_wr;

  function automatic logic is_mis(input logic [2:0] bt, input logic [1:0] off);
`ifdef DM_ALIGN_EXC_EN
    return ((bt == 3'd0) && (off != 2'd0)) || (((bt == 3'd1) || (bt == 3'd3)) && off[0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] w, input logic [1:0] off, input logic [2:0] bt);
    logic [31:0] v;
    int sh;
    if (bt == 3'd1 || bt == 3'd3) begin
      sh = 16 * off[1];
      v = (w >> sh) & 32'hFFFF;
      if (bt == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else if (bt == 3'd2 || bt == 3'd4) begin
      sh = 8 * off;
      v = (w >> sh) & 32'hFF;
      if (bt == 3'd2 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_value(input logic [31:0] old, input logic [1:0] off,
                                              input logic [2:0] bt, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (bt == 3'd1 || bt == 3'd3) begin
      sh = 16 * off[1];
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((wd & 32'hFFFF) << sh);
    end else if (bt == 3'd2 || bt == 3'd4) begin
      sh = 8 * off;
      mask = 32'hFF << sh;
      return (old & ~mask) | ((wd & 32'hFF) << sh);
    end
    return wd;
  endfunction

  task automatic model_reset();
    m_left = 0; m_done = 1'b0; m_adel = 1'b0; m_ades = 1'b0; m_rdata = 32'd0;
  endtask

  task automatic model_complete();
    m_done = 1'b1;
    if (p_bt > 3'd4)                  m_rdata = 32'd0;
    else if (is_mis(p_bt, p_addr[1:0])) begin
      if (p_we) m_ades = 1'b1;
      else      m_adel = 1'b1;
    end
    else if (!p_we)                   m_rdata = load_value(mm[p_idx], p_addr[1:0], p_bt);
    else                              mm[p_idx] = store_value(mm[p_idx], p_addr[1:0], p_bt, p_wd);
  endtask

  task automatic model_accept();
    int lat;
    p_we = we; p_addr = addr; p_bt = bit_type; p_wd = wdata;
    p_idx = int'((addr >> 2) & 32'hFFF);
    p_rd0 = rd_cnt; p_wr0 = wr_cnt;
    m_accepts++;
    if (bit_type > 3'd4 || is_mis(bit_type, addr[1:0])) begin
      lat = 1; p_exp_rd = 0; p_exp_wr = 0;
    end else if (!we) begin
      lat = 3; p_exp_rd = 1; p_exp_wr = 0;
    end else if (bit_type == 3'd0) begin
      lat = 2; p_exp_rd = 0; p_exp_wr = 1;
    end else begin
      lat = 4; p_exp_rd = 1; p_exp_wr = 1;
    end
    m_left = lat - 1;
    if (m_left == 0) model_complete();
  endtask

  task automatic model_step();
    m_done = 1'b0; m_adel = 1'b0; m_ades = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) model_complete();
    end else if (req) begin
      model_accept();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mm[i] = init_word(i);
    m_accepts = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  int dut_dones = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("rdata", rdata, m_rdata);
      chk("exc_adel", {31'd0, exc_adel}, {31'd0, m_adel});
      chk("exc_ades", {31'd0, exc_ades}, {31'd0, m_ades});
      if (m_done) begin
        chk("mem_word", ram[p_idx], mm[p_idx]);
        chk("read_count", rd_cnt - p_rd0, p_exp_rd);
        chk("write_count", wr_cnt - p_wr0, p_exp_wr);
      end
      if (done) dut_dones++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input logic w, input logic [31:0] a, input logic [2:0] bt,
                       input logic [31:0] wd, output int lat);
    int guard;
    guard = 0;
    lat = -1;
    @(posedge clk); #1;
    while (m_left > 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    req = 1'b1; we = w; addr = a; bit_type = bt; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic rand_op();
    we       = 1'($urandom_range(0, 1));
    bit_type = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    addr     = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
    wdata    = $urandom;
  endtask

  initial begin
    int lat, r0, w0, a0, d0;
    req = 1'b0; we = 1'b0; addr = 32'd0; bit_type = 3'd0; wdata = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Word store then load back
    do_op(1'b1, 32'h10, 3'd0, 32'hDEADBEEF, lat); chk("sw_latency", lat, 2);
    do_op(1'b0, 32'h10, 3'd0, 32'd0, lat);        chk("lw_latency", lat, 3);
    chk("lw_0x10", rdata, 32'hDEADBEEF);

    // Sub-word load extension
    do_op(1'b1, 32'h20, 3'd0, 32'h80FF7F01, lat);
    do_op(1'b0, 32'h23, 3'd2, 32'd0, lat); chk("lb_0x23", rdata, 32'hFFFFFF80);
    do_op(1'b0, 32'h23, 3'd4, 32'd0, lat); chk("lbu_0x23", rdata, 32'h00000080);
    do_op(1'b0, 32'h20, 3'd1, 32'd0, lat); chk("lh_0x20", rdata, 32'h00007F01);
    do_op(1'b0, 32'h22, 3'd1, 32'd0, lat); chk("lh_0x22", rdata, 32'hFFFF80FF);

    // Byte store read-modify-write
    do_op(1'b1, 32'h30, 3'd0, 32'h11223344, lat);
    r0 = rd_cnt; w0 = wr_cnt;
    do_op(1'b1, 32'h31, 3'd2, 32'h000000AA, lat); chk("sb_latency", lat, 4);
    chk("sb_mem", ram[12], 32'h1122AA44);
    chk("sb_reads", rd_cnt - r0, 1);
    chk("sb_writes", wr_cnt - w0, 1);

    // Misaligned word load
    r0 = rd_cnt;
    do_op(1'b0, 32'h32, 3'd0, 32'd0, lat);
`ifdef DM_ALIGN_EXC_EN
    chk("lw_mis_latency", lat, 1);
    chk("lw_mis_adel", {31'd0, exc_adel}, 32'd1);
    chk("lw_mis_rdata", rdata, 32'hFFFF80FF);
    chk("lw_mis_reads", rd_cnt - r0, 0);
`else
    chk("lw_mis_latency", lat, 3);
    chk("lw_mis_rdata", rdata, 32'h1122AA44);
    chk("lw_mis_reads", rd_cnt - r0, 1);
`endif

    // Undefined access type
    r0 = rd_cnt;
    do_op(1'b0, 32'h10, 3'd5, 32'd0, lat);
    chk("undef_latency", lat, 1);
    chk("undef_rdata", rdata, 32'd0);
    chk("undef_reads", rd_cnt - r0, 0);

    // Reset during the write phase of a half store
    w0 = wr_cnt;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h30; bit_type = 3'd1; wdata = 32'h5555;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (mem_we) break;
    end
    chk("sh_reached_wr", {31'd0, mem_we}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_kept", ram[12], 32'h1122AA44);
    chk("abort_no_write", wr_cnt - w0, 0);
    do_op(1'b0, 32'h30, 3'd0, 32'd0, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_lw", rdata, 32'h1122AA44);

    // Randomized traffic, req toggling
    a0 = m_accepts; d0 = dut_dones;
    repeat (600) begin
      @(posedge clk); #1;
      req = ($urandom_range(0, 3) != 0);
      rand_op();
    end
    @(posedge clk); #1 req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rand_done_count", dut_dones - d0, m_accepts - a0);

    // req held high: alternating sw/lw pairs accepted back-to-back from RESP
    a0 = m_accepts; d0 = dut_dones;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; bit_type = 3'd0;
    addr = 32'($urandom_range(0, 255)) << 2; wdata = $urandom;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i > 0 && !busy) chk("b2b_no_bubble", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      if (m_left == 0) begin
        if (we) begin
          we = 1'b0;
        end else begin
          we = 1'b1;
          addr = 32'($urandom_range(0, 255)) << 2;
          wdata = $urandom;
        end
      end
    end
    req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("b2b_done_count", dut_dones - d0, m_accepts - a0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the data memory.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  access request from pipeline MEM stage.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port addr  input  32  byte address.
REQ-007 SHALL have port bit_type  input  3  000 word, 001 half, 010 byte, 011 half-unsigned, 100 byte-unsigned.
REQ-008 SHALL have port wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port busy  output  1  controller cannot accept; pipeline stalls.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  extended load result.
REQ-012 SHALL have port exc_adel / exc_ades  output  1 each  misaligned load / store.
REQ-013 SHALL have ports mem_en, mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output 32), mem_rdata (input 32): single-port synchronous RAM, read data valid the cycle after mem_en with mem_we=0.

Function
REQ-014 SHALL implement FSM states IDLE, RD, CAP, WR, RESP; busy = state not in {IDLE, RESP}.
REQ-015 SHALL accept a request when req=1 in IDLE or RESP, latching addr, bit_type, we, wdata; req is ignored while busy.
REQ-016 Word store: accept -> WR (mem_en=1, mem_we=1, mem_addr=addr[ADDR_W+1:2]) -> RESP; done 2 cycles after accept.
REQ-017 Load: accept -> RD (mem_en=1, mem_we=0) -> CAP (mem_rdata extended and registered into rdata) -> RESP; done 3 cycles after accept.
REQ-018 Half/byte store: read-modify-write, accept -> RD -> CAP (merge wdata low bits into the lane selected by addr[1] or addr[1:0]) -> WR -> RESP; done 4 cycles after accept; unselected bytes unchanged.
REQ-019 Load extension: half lane = addr[1], byte lane = addr[1:0]; signed types sign-extend, unsigned types zero-extend.
REQ-020 rdata SHALL hold its value from CAP until the next load's CAP; stores do not alter rdata.
REQ-021 Undefined bit_type (101-111): no memory access, accept -> RESP, done after 1 cycle, rdata=0, no exception.
REQ-022 mem_en and mem_we SHALL be registered outputs, asserted only in RD/WR, 0 otherwise.
REQ-023 Accept in RESP SHALL behave identically to accept in IDLE (back-to-back, no bubble).

Reset
REQ-024 Reset low SHALL immediately force IDLE, busy=0, done=0, rdata=0, exc_adel=exc_ades=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset asserted mid-operation SHALL abort it; no memory write occurs after reset assertion; the aborted request does not resume.

Configuration
REQ-026 With DM_ALIGN_EXC_EN defined: word with addr[1:0]!=0 or half with addr[0]!=0 SHALL skip memory, go accept -> RESP, pulse done with exc_adel (load) or exc_ades (store) for that same cycle; rdata unchanged.
REQ-027 Without DM_ALIGN_EXC_EN: exception ports tied 0; word ignores addr[1:0], half ignores addr[0]; access proceeds normally.

Structure
REQ-028 Shared package dm_pkg SHALL hold bit_type codes and the FSM state encoding.
REQ-029 Load lane select/extension SHALL be a sub-module dm_load_ext (combinational), instantiated once for CAP.

Verification
REQ-030 Word store 0xDEADBEEF at 0x10, then lw 0x10 -> done 2 then 3 cycles after accept; rdata=0xDEADBEEF.
REQ-031 Memory word 0x80FF7F01 at 0x20: lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x20 -> 0x00007F01; lh 0x22 -> 0xFFFF80FF.
REQ-032 Word 0x11223344 at 0x30, sb 0xAA to 0x31 -> one read, one write; memory=0x1122AA44; done 4 cycles after accept.
REQ-033 With DM_ALIGN_EXC_EN, lw 0x32 -> no mem_en, done and exc_adel high 1 cycle after accept; without macro, same access reads word 0x30.
REQ-034 Reset pulsed low during WR of an sh -> mem_we drops immediately, memory unchanged, outputs at reset values, next request serviced normally.
REQ-035 req held high for consecutive lw/sw pairs -> each accepted in RESP cycle, busy never deasserts between them except in RESP, no lost or duplicated done.
